ram_burst_tracker: RTL and testbench

- Consumes the filtered, strobed RAM-bus samples from the RAM sampler and reconstructs synchronous burst transactions.
- Sequences address-latch → latency wait → data phase, auto-incrementing the word address per data beat.
- Emits one trace packet per data word into an internal FIFO with a valid/ready output handshake toward the trace/USB packetizer.

---
 rtl/ram_burst_tracker.sv | 133 +++++++++++++
 tb/tb_ram_burst_tracker.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_burst_tracker.sv
// Rebuilds RAM bus bursts (latch -> latency -> data beats) into one trace packet per data word.
// Latency: a packet is visible on pkt_valid the cycle after its data strobe. Backpressure: a FIFO of
// 2^FIFO_AW entries absorbs stalls; a push into a full FIFO is dropped and sets sticky overflow.
// Optional drop counter output is enabled by defining RAM_TRACER_DROP_COUNT_EN.
module ram_burst_tracker #(
    parameter int FIFO_AW = 4,
    parameter int LAT_W   = 4
) (
    input  logic             mclk,
    input  logic             reset,
    input  logic             enable,
    input  logic [LAT_W-1:0] cfg_latency,
    input  logic [22:0]      filter_a,
    input  logic [15:0]      filter_d,
    input  logic [1:0]       filter_ublb,
    input  logic             filter_read,
    input  logic             filter_write,
    input  logic             filter_addr_latch,
    input  logic             filter_strobe,
    output logic [41:0]      pkt_data,
    output logic             pkt_valid,
    input  logic             pkt_ready,
    output logic             overflow,
    input  logic             overflow_clr,
    output logic             busy
`ifdef RAM_TRACER_DROP_COUNT_EN
    ,
    output logic [15:0]      drop_count
`endif
);

    localparam int DEPTH = 1 << FIFO_AW;

    typedef enum logic [1:0] {IDLE, LATENCY, DATA} state_t;

    state_t             state_q;
    logic [22:0]        cur_addr_q;
    logic [LAT_W-1:0]   lat_cnt_q;

    logic [41:0]        mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;

    logic beat, push_req, pop, full, push_ok, drop;
    logic [41:0] push_word;

    assign beat      = filter_read | filter_write;
    assign push_req  = enable && filter_strobe && !filter_addr_latch && (state_q == DATA) && beat;
    assign push_word = {filter_write, filter_ublb, cur_addr_q, filter_d};
    assign pop       = pkt_valid && pkt_ready;
    // Count never exceeds DEPTH, so its MSB alone marks a full FIFO.
    assign full      = cnt_q[FIFO_AW];
    assign push_ok   = push_req && (!full || pop);
    assign drop      = push_req && full && !pop;

    assign pkt_valid = (cnt_q != '0);
    assign pkt_data  = pkt_valid ? mem_q[rd_ptr_q] : '0;
    assign busy      = (state_q != IDLE);
    assign overflow  = ovf_q;

    always_ff @(posedge mclk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cur_addr_q <= '0;
            lat_cnt_q  <= '0;
        end else if (!enable) begin
            state_q <= IDLE;
        end else if (filter_strobe) begin
            if (filter_addr_latch) begin
                cur_addr_q <= filter_a;
                lat_cnt_q  <= cfg_latency;
                state_q    <= (cfg_latency == '0) ? DATA : LATENCY;
            end else if (!beat) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    LATENCY: begin
                        lat_cnt_q <= lat_cnt_q - LAT_W'(1);
                        if (lat_cnt_q == LAT_W'(1)) state_q <= DATA;
                    end
                    DATA:    cur_addr_q <= cur_addr_q + 23'd1;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (push_ok && !pop)      cnt_d = cnt_q + 1'b1;
        else if (!push_ok && pop) cnt_d = cnt_q - 1'b1;
        ovf_d = ovf_q;
        if (drop)              ovf_d = 1'b1;
        else if (overflow_clr) ovf_d = 1'b0;
    end

    always_ff @(posedge mclk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_word;
    end

    always_ff @(posedge mclk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

`ifdef RAM_TRACER_DROP_COUNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (overflow_clr)                      drop_cnt_d = drop ? 16'd1 : 16'd0;
        else if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    end

    always_ff @(posedge mclk or negedge reset) begin
        if (!reset) drop_cnt_q <= '0;
        else        drop_cnt_q <= drop_cnt_d;
    end

    assign drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_ram_burst_tracker.sv
// Bench for ram_burst_tracker: vector table, directed burst sequences and a randomized run,
// all scored against a queue-based model of the burst rules.
module tb_ram_burst_tracker;
    localparam int FIFO_AW = 4;
    localparam int LAT_W   = 4;
    localparam int DEPTH   = 16;

    logic mclk = 1'b0;
    logic reset, enable, filter_read, filter_write, filter_addr_latch, filter_strobe;
    logic pkt_valid, pkt_ready, overflow, overflow_clr, busy;
    logic [LAT_W-1:0] cfg_latency;
    logic [22:0] filter_a;
    logic [15:0] filter_d;
    logic [1:0]  filter_ublb;
    logic [41:0] pkt_data;
`ifdef RAM_TRACER_DROP_COUNT_EN
    logic [15:0] drop_count;
`endif

    always #5 mclk = ~mclk;

    ram_burst_tracker #(.FIFO_AW(FIFO_AW), .LAT_W(LAT_W)) dut (
        .mclk(mclk), .reset(reset), .enable(enable), .cfg_latency(cfg_latency),
        .filter_a(filter_a), .filter_d(filter_d), .filter_ublb(filter_ublb),
        .filter_read(filter_read), .filter_write(filter_write),
        .filter_addr_latch(filter_addr_latch), .filter_strobe(filter_strobe),
        .pkt_data(pkt_data), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
        .overflow(overflow), .overflow_clr(overflow_clr), .busy(busy)
`ifdef RAM_TRACER_DROP_COUNT_EN
        , .drop_count(drop_count)
`endif
    );

    int pass_cnt = 0;
    int total_cnt = 0;

    // Reference model: burst phase, strobes left before data, word address, packet queue.
    int          m_mode;    // 0 = no burst, 1 = waiting out latency, 2 = data phase
    int          m_wait;
    logic [22:0] m_addr;
    logic [41:0] m_q[$];
    logic        m_ovf;
    int          m_drops;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic void model_reset();
        m_mode = 0; m_wait = 0; m_addr = '0; m_q.delete(); m_ovf = 1'b0; m_drops = 0;
    endfunction

    function automatic void model_edge();
        bit pop, push, drop;
        logic [41:0] w;
        if (!reset) begin
            model_reset();
            return;
        end
        pop  = (m_q.size() != 0) && pkt_ready;
        push = 1'b0;
        w    = '0;
        if (!enable) m_mode = 0;
        else if (filter_strobe) begin
            if (filter_addr_latch) begin
                m_addr = filter_a;
                m_wait = int'(cfg_latency);
                m_mode = (m_wait == 0) ? 2 : 1;
            end else if (!(filter_read || filter_write)) begin
                m_mode = 0;
            end else if (m_mode == 1) begin
                m_wait--;
                if (m_wait == 0) m_mode = 2;
            end else if (m_mode == 2) begin
                push = 1'b1;
                w = {filter_write, filter_ublb, m_addr, filter_d};
                m_addr = m_addr + 23'd1;
            end
        end
        drop = push && (m_q.size() == DEPTH) && !pop;
        if (pop) void'(m_q.pop_front());
        if (push && !drop) m_q.push_back(w);
        if (drop) m_ovf = 1'b1;
        else if (overflow_clr) m_ovf = 1'b0;
        if (overflow_clr) m_drops = drop ? 1 : 0;
        else if (drop && m_drops < 65535) m_drops++;
    endfunction

    task automatic compare_model();
        logic [41:0] head;
        head = (m_q.size() != 0) ? m_q[0] : 42'd0;
        chk("model_valid", pkt_valid, (m_q.size() != 0));
        chk("model_data", pkt_data, head);
        chk("model_busy", busy, (m_mode != 0));
        chk("model_overflow", overflow, m_ovf);
`ifdef RAM_TRACER_DROP_COUNT_EN
        chk("model_drop_count", drop_count, m_drops);
`endif
    endtask

    task automatic tick();
        @(posedge mclk);
        model_edge();
        #1;
        compare_model();
    endtask

    // One strobed bus sample followed by one quiet cycle.
    task automatic strobe(input bit latch, input bit rd, input bit wr,
                          input logic [22:0] a, input logic [15:0] d);
        filter_addr_latch = latch; filter_read = rd; filter_write = wr;
        filter_a = a; filter_d = d; filter_strobe = 1'b1;
        tick();
        filter_strobe = 1'b0; filter_addr_latch = 1'b0; filter_read = 1'b0; filter_write = 1'b0;
        tick();
    endtask

    task automatic expect_pop(input string name, input logic [41:0] exp);
        chk({name, "_valid"}, pkt_valid, 1'b1);
        chk(name, pkt_data, exp);
        pkt_ready = 1'b1;
        tick();
        pkt_ready = 1'b0;
    endtask

    task automatic drain_count(output int n);
        n = 0;
        pkt_ready = 1'b1;
        while (pkt_valid && n < 40) begin
            tick();
            n++;
        end
        pkt_ready = 1'b0;
        tick();
    endtask

    typedef struct {
        bit          latch;
        bit          rd;
        logic [22:0] a;
        logic [15:0] d;
        bit          exp_busy;
        bit          exp_valid;
        logic [41:0] exp_head;
    } vec_t;

    vec_t tv[8];

    initial begin
        logic [41:0] h0;
        int n;
        h0 = {1'b0, 2'b11, 23'h000100, 16'h00A0};
        tv[0] = '{1'b1, 1'b0, 23'h000100, 16'h0000, 1'b1, 1'b0, 42'd0};
        tv[1] = '{1'b0, 1'b1, 23'h0,      16'h0000, 1'b1, 1'b0, 42'd0};
        tv[2] = '{1'b0, 1'b1, 23'h0,      16'h0000, 1'b1, 1'b0, 42'd0};
        tv[3] = '{1'b0, 1'b1, 23'h0,      16'h00A0, 1'b1, 1'b1, h0};
        tv[4] = '{1'b0, 1'b1, 23'h0,      16'h00A1, 1'b1, 1'b1, h0};
        tv[5] = '{1'b0, 1'b1, 23'h0,      16'h00A2, 1'b1, 1'b1, h0};
        tv[6] = '{1'b0, 1'b1, 23'h0,      16'h00A3, 1'b1, 1'b1, h0};
        tv[7] = '{1'b0, 1'b0, 23'h0,      16'h0000, 1'b0, 1'b1, h0};

        reset = 1'b0; enable = 1'b1; cfg_latency = '0; filter_a = '0; filter_d = '0;
        filter_ublb = 2'b11; filter_read = 1'b0; filter_write = 1'b0;
        filter_addr_latch = 1'b0; filter_strobe = 1'b0; pkt_ready = 1'b0; overflow_clr = 1'b0;
        model_reset();
        tick(); tick();
        chk("rst_valid", pkt_valid, 1'b0);
        chk("rst_data", pkt_data, 42'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_overflow", overflow, 1'b0);
        reset = 1'b1;
        tick();

        // Read burst, latency 2, from the vector table.
        cfg_latency = 4'd2;
        for (int i = 0; i < 8; i++) begin
            strobe(tv[i].latch, tv[i].rd, 1'b0, tv[i].a, tv[i].d);
            chk($sformatf("tv%0d_busy", i), busy, tv[i].exp_busy);
            chk($sformatf("tv%0d_valid", i), pkt_valid, tv[i].exp_valid);
            chk($sformatf("tv%0d_head", i), pkt_data, tv[i].exp_head);
        end
        for (int i = 0; i < 4; i++)
            expect_pop($sformatf("rd_pkt%0d", i), {1'b0, 2'b11, 23'h100 + 23'(i), 16'hA0 + 16'(i)});

        // Write burst across the address wrap, zero latency.
        cfg_latency = 4'd0;
        strobe(1'b1, 1'b0, 1'b0, 23'h7FFFFE, 16'h0);
        for (int i = 0; i < 3; i++) strobe(1'b0, 1'b0, 1'b1, 23'h0, 16'h1111 * 16'(i + 1));
        strobe(1'b0, 1'b0, 1'b0, 23'h0, 16'h0);
        expect_pop("wrap0", {1'b1, 2'b11, 23'h7FFFFE, 16'h1111});
        expect_pop("wrap1", {1'b1, 2'b11, 23'h7FFFFF, 16'h2222});
        expect_pop("wrap2", {1'b1, 2'b11, 23'h000000, 16'h3333});

        // Mid-burst latch restarts the latency wait at the new address.
        cfg_latency = 4'd1;
        strobe(1'b1, 1'b0, 1'b0, 23'h10, 16'h0);
        strobe(1'b0, 1'b1, 1'b0, 23'h0, 16'h0);
        strobe(1'b0, 1'b1, 1'b0, 23'h0, 16'hB0);
        strobe(1'b0, 1'b1, 1'b0, 23'h0, 16'hB1);
        strobe(1'b1, 1'b0, 1'b0, 23'h2000, 16'h0);
        strobe(1'b0, 1'b1, 1'b0, 23'h0, 16'hFF);
        strobe(1'b0, 1'b1, 1'b0, 23'h0, 16'hB2);
        strobe(1'b0, 1'b0, 1'b0, 23'h0, 16'h0);
        expect_pop("relatch0", {1'b0, 2'b11, 23'h10, 16'hB0});
        expect_pop("relatch1", {1'b0, 2'b11, 23'h11, 16'hB1});
        expect_pop("relatch2", {1'b0, 2'b11, 23'h2000, 16'hB2});
        chk("relatch_empty", pkt_valid, 1'b0);

        // 17 words into a 16-entry FIFO with no consumer.
        cfg_latency = 4'd0;
        strobe(1'b1, 1'b0, 1'b0, 23'h0, 16'h0);
        for (int i = 0; i < 17; i++) strobe(1'b0, 1'b0, 1'b1, 23'h0, 16'(i));
        strobe(1'b0, 1'b0, 1'b0, 23'h0, 16'h0);
        chk("ovf_set", overflow, 1'b1);
`ifdef RAM_TRACER_DROP_COUNT_EN
        chk("ovf_drop_count", drop_count, 16'd1);
`endif
        for (int i = 0; i < 16; i++)
            expect_pop($sformatf("ovf_pkt%0d", i), {1'b1, 2'b11, 23'(i), 16'(i)});
        chk("ovf_drained", pkt_valid, 1'b0);
        overflow_clr = 1'b1; tick(); overflow_clr = 1'b0; tick();
        chk("ovf_cleared", overflow, 1'b0);

        // Full FIFO with a simultaneous pop and push: nothing dropped.
        strobe(1'b1, 1'b0, 1'b0, 23'h300, 16'h0);
        for (int i = 0; i < 16; i++) strobe(1'b0, 1'b1, 1'b0, 23'h0, 16'(i));
        filter_read = 1'b1; filter_d = 16'h5555; filter_strobe = 1'b1; pkt_ready = 1'b1;
        tick();
        filter_strobe = 1'b0; filter_read = 1'b0; pkt_ready = 1'b0;
        tick();
        chk("full_pop_no_ovf", overflow, 1'b0);
        strobe(1'b0, 1'b0, 1'b0, 23'h0, 16'h0);
        drain_count(n);
        chk("full_pop_count", n, 16);

        // Async reset in the data phase with 5 packets queued.
        strobe(1'b1, 1'b0, 1'b0, 23'h500, 16'h0);
        for (int i = 0; i < 5; i++) strobe(1'b0, 1'b1, 1'b0, 23'h0, 16'(i));
        chk("pre_rst_busy", busy, 1'b1);
        #3 reset = 1'b0;
        #1;
        chk("async_rst_valid", pkt_valid, 1'b0);
        chk("async_rst_busy", busy, 1'b0);
        tick(); tick();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) strobe(1'b0, 1'b1, 1'b0, 23'h0, 16'(i));
        chk("post_rst_no_pkt", pkt_valid, 1'b0);

        // Randomized traffic, including enable drops and overflow clears.
        for (int c = 0; c < 3000; c++) begin
            enable            = ($urandom_range(0, 24) != 0);
            cfg_latency       = LAT_W'($urandom_range(0, 3));
            filter_strobe     = $urandom_range(0, 1);
            filter_addr_latch = ($urandom_range(0, 11) == 0);
            filter_read       = ($urandom_range(0, 9) < 6);
            filter_write      = ($urandom_range(0, 9) < 4);
            filter_a          = 23'($urandom);
            filter_d          = 16'($urandom);
            filter_ublb       = 2'($urandom);
            pkt_ready         = (c < 1500) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 1);
            overflow_clr      = ($urandom_range(0, 59) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
